// File: rtl/vga_stream_out.sv
// Ready/valid RGB stream to VGA pins with raster timing and frame alignment.
// Define VGA_TEST_PATTERN_EN to add colour bar / checker / grey test patterns.
module vga_stream_out #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic [23:0] snk_data,
    input  logic        snk_valid,
    input  logic        snk_sop,
    output logic        snk_ready,
    input  logic [3:0]  vga_sw,
    output logic [7:0]  vga_red,
    output logic [7:0]  vga_green,
    output logic [7:0]  vga_blue,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_sync,
    output logic        vga_blank,
    output logic [15:0] underflow_cnt
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic {ALIGN, RUN} state_t;

    state_t        state_q, state_d;
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic [24:0]   mem_q [FIFO_DEPTH];
    logic [AW:0]   wr_q, rd_q;
    logic [15:0]   uf_q;
    logic          hs_q, vs_q, blank_q;
    logic [23:0]   rgb_q, rgb_d;
    logic [24:0]   head;
    logic          empty, full, push, pop, show, uf_hit;
    logic          active, origin, frame_end;

    assign empty     = wr_q == rd_q;
    assign full      = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign head      = mem_q[rd_q[AW-1:0]];
    assign push      = snk_valid && !full;
    assign snk_ready = !full;
    assign active    = (h_q < H_ACT) && (v_q < V_ACT);
    assign origin    = (h_q == '0) && (v_q == '0);
    assign frame_end = (h_q == H_LAST) && (v_q == V_LAST);

    always_comb begin
        h_d = (h_q == H_LAST) ? '0 : h_q + 1'b1;
        v_d = v_q;
        if (h_q == H_LAST) begin
            v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
        end
    end

    // A sop at the head must coincide with the origin; any disagreement realigns.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        show    = 1'b0;
        uf_hit  = 1'b0;
        unique case (state_q)
            ALIGN: begin
                if (!empty) begin
                    if (!head[24]) begin
                        pop = 1'b1;
                    end else if (frame_end) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (active) begin
                    if (empty) begin
                        uf_hit  = 1'b1;
                        state_d = ALIGN;
                    end else if (head[24] != origin) begin
                        pop     = origin;
                        state_d = ALIGN;
                    end else begin
                        pop  = 1'b1;
                        show = 1'b1;
                    end
                end
            end
            default: state_d = ALIGN;
        endcase
    end

`ifdef VGA_TEST_PATTERN_EN
    logic [2:0]  bar;
    logic [23:0] pat;

    always_comb begin
        bar = 3'(h_q / HW'(H_ACTIVE / 8));
        case (vga_sw)
            4'd1:    pat = {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}};
            4'd2:    pat = (h_q[3] ^ v_q[3]) ? 24'hFFFFFF : 24'h000000;
            4'd3:    pat = 24'h808080;
            default: pat = 24'h000000;
        endcase
        rgb_d = '0;
        if (active) begin
            rgb_d = (vga_sw != 4'd0) ? pat : (show ? head[23:0] : 24'h0);
        end
    end
`else
    logic unused_sw;
    assign unused_sw = ^vga_sw;

    always_comb begin
        rgb_d = '0;
        if (show) begin
            rgb_d = head[23:0];
        end
    end
`endif

    always_ff @(posedge clk_clk) begin
        if (push) begin
            mem_q[wr_q[AW-1:0]] <= {snk_sop, snk_data};
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q <= ALIGN;
            h_q     <= '0;
            v_q     <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            uf_q    <= '0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            blank_q <= 1'b0;
            rgb_q   <= '0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
            if (push) wr_q <= wr_q + 1'b1;
            if (pop) rd_q <= rd_q + 1'b1;
            if (uf_hit && uf_q != 16'hFFFF) uf_q <= uf_q + 1'b1;
            hs_q    <= !((h_q >= HS_BEG) && (h_q < HS_END));
            vs_q    <= !((v_q >= VS_BEG) && (v_q < VS_END));
            blank_q <= active;
            rgb_q   <= rgb_d;
        end
    end

    assign vga_red       = rgb_q[23:16];
    assign vga_green     = rgb_q[15:8];
    assign vga_blue      = rgb_q[7:0];
    assign vga_hs        = hs_q;
    assign vga_vs        = vs_q;
    assign vga_sync      = 1'b0;
    assign vga_blank     = blank_q;
    assign underflow_cnt = uf_q;
endmodule

// File: tb/tb_vga_stream_out.sv
// Bench for vga_stream_out on a shrunken raster: 16x8 active, 24x12 total.
// Expected pixels flow through a scoreboard queue filled by the stream driver.
module tb_vga_stream_out;
    localparam int HA = 16, HF = 2, HS = 3, HB = 3, HT = HA + HF + HS + HB;
    localparam int VA = 8, VF = 1, VS = 2, VB = 1, VT = VA + VF + VS + VB;
    localparam int DEPTH = 8;
    localparam int NPIX = HA * VA;
    localparam int M_BLACK = 0, M_STREAM = 1, M_SKIP = 2, M_PAT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] snk_data = '0;
    logic        snk_valid = 1'b0;
    logic        snk_sop = 1'b0;
    logic        snk_ready;
    logic [3:0]  vga_sw = '0;
    logic [7:0]  vga_red, vga_green, vga_blue;
    logic        vga_hs, vga_vs, vga_sync, vga_blank;
    logic [15:0] underflow_cnt;

    always #5 clk = ~clk;

    vga_stream_out #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_clk(clk),
        .reset_reset(rst),
        .snk_data(snk_data),
        .snk_valid(snk_valid),
        .snk_sop(snk_sop),
        .snk_ready(snk_ready),
        .vga_sw(vga_sw),
        .vga_red(vga_red),
        .vga_green(vga_green),
        .vga_blue(vga_blue),
        .vga_hs(vga_hs),
        .vga_vs(vga_vs),
        .vga_sync(vga_sync),
        .vga_blank(vga_blank),
        .underflow_cnt(underflow_cnt)
    );

    int total = 0;
    int bad = 0;
    logic [23:0] exp_q[$];
    int modes[4] = '{M_SKIP, M_SKIP, M_SKIP, M_SKIP};
    int bh = 0, bv = 0, ph = 0, pv = 0, rf = -1;
    bit ov = 1'b0;
    logic [23:0] bars[8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int mode_of(int f);
        if (f >= 0 && f < 4) return modes[f];
        return M_SKIP;
    endfunction

    function automatic logic [23:0] pat_of(int x, int y, logic [3:0] sw);
        case (sw)
            4'd1: return bars[x / (HA / 8)];
            4'd2: return (((x >> 3) ^ (y >> 3)) & 1) != 0 ? 24'hFFFFFF : 24'h0;
            4'd3: return 24'h808080;
            default: return 24'h0;
        endcase
    endfunction

    // Reference raster: (ph,pv) is the position the registered outputs show.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bh <= 0;
            bv <= 0;
            ov <= 1'b0;
        end else begin
            ph <= bh;
            pv <= bv;
            ov <= 1'b1;
            if (bh == HT - 1) begin
                bh <= 0;
                bv <= (bv == VT - 1) ? 0 : bv + 1;
            end else begin
                bh <= bh + 1;
            end
        end
    end

    always @(negedge clk) begin : mon
        logic [23:0] pix;
        bit act;
        bit avail;
        if (rst) begin
            rf = -1;
        end else if (ov) begin
            act = (ph < HA) && (pv < VA);
            pix = {vga_red, vga_green, vga_blue};
            chk("hs", vga_hs, !(ph >= HA + HF && ph < HA + HF + HS));
            chk("vs", vga_vs, !(pv >= VA + VF && pv < VA + VF + VS));
            chk("blank", vga_blank, act);
            chk("sync", vga_sync, 0);
            if (ph == 0 && pv == 0) rf++;
            if (!act) begin
                chk("pix_off", pix, 0);
            end else begin
                case (mode_of(rf))
                    M_BLACK: chk("pix_black", pix, 0);
                    M_STREAM: begin
                        avail = exp_q.size() > 0;
                        chk("sb_avail", avail, 1);
                        if (avail) chk("pix", pix, exp_q.pop_front());
                    end
                    M_PAT: chk("pat", pix, pat_of(ph, pv, vga_sw));
                    default: ;
                endcase
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        snk_valid = 1'b0;
        snk_sop = 1'b0;
        #1;
        chk("rst_hs", vga_hs, 1);
        chk("rst_vs", vga_vs, 1);
        chk("rst_blank", vga_blank, 0);
        chk("rst_rgb", {vga_red, vga_green, vga_blue}, 0);
        chk("rst_uf", underflow_cnt, 0);
        chk("rst_ready", snk_ready, 1);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the beat is taken.
    task automatic send_beat(input logic [23:0] d, input bit s, input bit trk);
        int n = 0;
        snk_data = d;
        snk_sop = s;
        snk_valid = 1'b1;
        while (!snk_ready) begin
            @(negedge clk);
            n++;
            if (n > 3000) begin
                chk("ready_timeout", n, 0);
                break;
            end
        end
        if (trk) exp_q.push_back(d);
        @(negedge clk);
    endtask

    task automatic send_frame(input int f, input bit trk, input int nb,
                              input int stall_at, input int stall_len);
        for (int i = 0; i < nb; i++) begin
            send_beat(24'((f << 20) | ((i / HA) << 10) | (i % HA)), i == 0, trk);
            if (i == stall_at) begin
                snk_valid = 1'b0;
                repeat (stall_len) @(negedge clk);
            end
        end
    endtask

    task automatic go_idle();
        snk_valid = 1'b0;
        snk_sop = 1'b0;
    endtask

    // Returns once raster frame f has finished its active lines.
    task automatic wait_frame(input int f);
        int n = 0;
        while (!(rf == f && pv >= VA)) begin
            @(negedge clk);
            #1;
            n++;
            if (n > 4000) begin
                chk("wait_timeout", n, 0);
                break;
            end
        end
    endtask

    initial begin
        // Idle raster: timing only, black everywhere, no underflow.
        modes = '{M_BLACK, M_BLACK, M_SKIP, M_SKIP};
        do_reset();
        wait_frame(1);
        chk("idle_uf", underflow_cnt, 0);
        chk("idle_ready", snk_ready, 1);

        // Continuous frames displayed one raster frame after alignment.
        modes = '{M_BLACK, M_STREAM, M_STREAM, M_STREAM};
        do_reset();
        send_frame(1, 1, NPIX, -1, 0);
        send_frame(2, 1, NPIX, -1, 0);
        send_frame(3, 1, NPIX, -1, 0);
        go_idle();
        wait_frame(3);
        chk("cont_uf", underflow_cnt, 0);
        chk("cont_sb_left", exp_q.size(), 0);

        // Mid-frame stall: one underflow, next frame realigns.
        modes = '{M_BLACK, M_STREAM, M_SKIP, M_STREAM};
        do_reset();
        send_frame(4, 1, NPIX, -1, 0);
        send_frame(5, 0, NPIX, 40, 60);
        send_frame(6, 1, NPIX, -1, 0);
        go_idle();
        wait_frame(3);
        chk("stall_uf", underflow_cnt, 1);
        chk("stall_sb_left", exp_q.size(), 0);

        // Leading non-sop beats are discarded.
`ifndef VGA_TEST_PATTERN_EN
        vga_sw = 4'd3;
`endif
        modes = '{M_BLACK, M_STREAM, M_STREAM, M_SKIP};
        do_reset();
        for (int i = 0; i < 37; i++) send_beat(24'h0F0000 + 24'(i), 1'b0, 1'b0);
        send_frame(7, 1, NPIX, -1, 0);
        send_frame(8, 1, NPIX, -1, 0);
        go_idle();
        wait_frame(2);
        chk("junk_uf", underflow_cnt, 0);
        chk("junk_sb_left", exp_q.size(), 0);
        vga_sw = 4'd0;

        // Early sop at (5,3): black for the rest, new frame from next origin.
        modes = '{M_BLACK, M_STREAM, M_STREAM, M_SKIP};
        do_reset();
        send_frame(9, 1, 3 * HA + 5, -1, 0);
        repeat (NPIX - (3 * HA + 5)) exp_q.push_back(24'h0);
        send_frame(10, 1, NPIX, -1, 0);
        go_idle();
        wait_frame(2);
        chk("mis_uf", underflow_cnt, 0);
        chk("mis_sb_left", exp_q.size(), 0);

`ifdef VGA_TEST_PATTERN_EN
        modes = '{M_PAT, M_PAT, M_PAT, M_SKIP};
        vga_sw = 4'd1;
        do_reset();
        wait_frame(0);
        vga_sw = 4'd2;
        wait_frame(1);
        vga_sw = 4'd3;
        wait_frame(2);
        chk("pat_uf", underflow_cnt, 0);
        vga_sw = 4'd0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
